// File: rtl/fpu_mul_arbiter_if.sv
// fpu_mul_arbiter_if: request/response channels between client blocks and the shared multiplier arbiter
interface fpu_mul_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic resp_valid;
  logic resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [31:0] resp_y;
  modport master(output req_valid, req_a, req_b, resp_ready, input req_ready, resp_valid, resp_id, resp_y);
  modport slave(input req_valid, req_a, req_b, resp_ready, output req_ready, resp_valid, resp_id, resp_y);
endinterface

// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter: round-robin sharing of one external single-precision multiplier among NUM_REQ clients
module fpu_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  fpu_mul_arbiter_if.slave bus,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_y,
  output logic busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int LAT_W = FPU_LAT > 1 ? $clog2(FPU_LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [ID_W-1:0] last, id, grant;
  logic [LAT_W-1:0] cnt;
  logic found;
  logic [31:0] a_sel, b_sel;
  // Lowest index above last wins, otherwise wrap to the lowest index at or below it
  always_comb begin
    grant = '0;
    found = 1'b0;
    a_sel = '0;
    b_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i] && ID_W'(i) <= last) begin
        grant = ID_W'(i);
        found = 1'b1;
      end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i] && ID_W'(i) > last) begin
        grant = ID_W'(i);
        found = 1'b1;
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == grant) begin
        a_sel = bus.req_a[32*i +: 32];
        b_sel = bus.req_b[32*i +: 32];
      end
    bus.req_ready = (rst_n && state == IDLE && found) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= ID_W'(NUM_REQ - 1);
      id <= '0;
      cnt <= '0;
      fpu_a <= '0;
      fpu_b <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id <= '0;
      bus.resp_y <= '0;
      busy <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          fpu_a <= a_sel;
          fpu_b <= b_sel;
          id <= grant;
          last <= grant;
          cnt <= LAT_W'(FPU_LAT - 1);
          busy <= 1'b1;
          state <= EXEC;
        end
        EXEC: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          bus.resp_y <= fpu_y;
          bus.resp_id <= id;
          bus.resp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          op_count <= &op_count ? op_count : op_count + 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
- Shares one combinational single-precision multiplier (`fpu`: a, b in, y out) among NUM_REQ requesters.
- Arbitration is round-robin. Operands are registered, the multiplier output is sampled after FPU_LAT cycles, and the tagged product is returned on one response channel with valid/ready backpressure.
- Sits between client blocks and the `fpu` instance, which is external and connected via the fpu_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- FPU_LAT, 1, cycles operands are held on fpu_a/fpu_b before fpu_y is sampled (≥1; covers multiplier settling or a later pipelined fpu).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*32  operand A; requester i at bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B; same packing as req_a.
- resp_valid  out  1  product available.
- resp_ready  in  1  consumer accepts product.
- resp_id  out  $clog2(NUM_REQ)  index of requester owning resp_y.
- resp_y  out  32  IEEE-754 single product.
- fpu_a  out  32  registered operand to fpu.a.
- fpu_b  out  32  registered operand to fpu.b.
- fpu_y  in  32  fpu.y.
- busy  out  1  high when state != IDLE.
- op_count  out  CNT_W  completed responses, saturating.

Behaviour:
- **Reset values** (async assert, sync-free deassert):
  - state=IDLE
  - req_ready=0, resp_valid=0, resp_id=0, resp_y=0
  - fpu_a=0, fpu_b=0
  - busy=0, op_count=0
  - rr pointer last=NUM_REQ-1, so requester 0 has first priority.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - Grant = first i with req_valid[i]=1, searching last+1, last+2, … modulo NUM_REQ.
  - req_ready is combinational: one-hot at the grant, and only in IDLE. req_ready[i] may depend on req_valid; req_valid must not depend on req_ready.
  - On handshake (req_valid[g] & req_ready[g]) at edge: fpu_a←req_a[g], fpu_b←req_b[g], id←g, last←g, cnt←FPU_LAT-1, →EXEC.
  - No valid: stay in IDLE; fpu_a/fpu_b hold their previous values (no toggling).
- **EXEC:**
  - req_ready=0.
  - cnt≠0: decrement.
  - cnt=0: resp_y←fpu_y, resp_id←id, resp_valid←1, →RESP.
- **RESP:**
  - req_ready=0.
  - resp_valid, resp_y and resp_id are held stable until resp_ready=1.
  - On resp_valid & resp_ready: resp_valid←0, op_count←op_count+1 (stays at all-ones once there), →IDLE.
- **Timing:** handshake in cycle k → EXEC cycles k+1..k+FPU_LAT → resp_valid first high in cycle k+FPU_LAT+1. Minimum spacing between accepts is FPU_LAT+2 cycles.
- **No combinational paths** from fpu_y to any output; resp_y is registered.
- **Fairness:** a continuously valid requester is served within NUM_REQ grants.
- **Request-side rules:** requesters must hold req_a/req_b stable while req_valid is high and unaccepted. Deasserting valid before grant is permitted; the arbiter simply skips that requester.
- **Result handling:** special values (zero, inf, NaN) pass through unchanged; the arbiter does not inspect the data.
- **Reset mid-operation:** the in-flight op is dropped and no response is issued. After reset, the next grant starts from requester 0.

Test Plan:
- **Single request:** req0 a=3fc00000 b=40000000, FPU_LAT=1 → req_ready[0] in same cycle; resp_valid 2 cycles later with resp_y=40400000, resp_id=0; op_count=1.
- **All four requesting simultaneously, held:** req i a=40400000 b=3f800000 → grants 0,1,2,3,0 in order; resp_id sequence matches; each resp_y=40400000; never more than one req_ready bit high.
- **Backpressure:** resp_ready=0 for 5 cycles after resp_valid → resp_y/resp_id constant, req_ready stays 0 while req1 is valid; req1 is granted the cycle after resp_ready=1.
- **Special values:**
  - 00000000×3f800000 → 00000000.
  - 7f800000×3f800000 → 7f800000.
  - 3f800000×3f800000 → 3f800000.
  - Repeat with FPU_LAT=3: resp_valid 4 cycles after accept.
- **Reset in EXEC:** assert rst_n=0 during EXEC → all outputs zero immediately; after release, no stale resp_valid; pending req2 and req0 → req0 granted first.
- **Saturation:** CNT_W=2, 5 completed ops → op_count sequence 1,2,3,3,3.
